// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter + register scoreboard for the 32x32 register file.
// Latency: grant is combinational; the write appears on rf_* the cycle after the grant.
// Backpressure: a requester waits (holding its request) until req_ready; issue waits on issue_stall.
//
// Ports:
//   clock, reset                 core clock, synchronous active-high reset
//   req_valid/req_dest/req_data  NREQ write-back requesters (0 = ALU, 1 = MUL, 2 = MEM)
//   req_ready                    one-hot grant, combinational
//   rf_writeEn/rf_dest_addr/rf_writeVal  registered register-file write port
//   issue_valid/_dest/_src1/_src2 instruction offered by the issue stage
//   issue_stall                  combinational RAW/WAW hazard stall
//   flush                        clears the scoreboard (in-flight write-backs still complete)
// Build option: define RF_WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed
// priority with the lowest index winning.

module rf_wb_arbiter #(
    parameter int NREQ = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*5-1:0] req_dest,
    input  logic [NREQ*32-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rf_writeEn,
    output logic [4:0]        rf_dest_addr,
    output logic [31:0]       rf_writeVal,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    input  logic [4:0]        issue_src1,
    input  logic [4:0]        issue_src2,
    output logic              issue_stall,
    input  logic              flush
);

    logic [NREQ-1:0] grant;
    logic            accept;
    logic [4:0]      acc_dest;
    logic [31:0]     acc_data;

    logic            wen_q,     wen_d;
    logic [4:0]      waddr_q,   waddr_d;
    logic [31:0]     wdata_q,   wdata_d;
    logic [31:0]     pending_q, pending_d;

`ifdef RF_WB_ROUND_ROBIN_EN
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic          rr_found;

    // Two passes emulate a circular search starting at ptr+1: first the
    // requesters above the last winner, then wrap to those at or below it.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req_valid[i] && (i > int'(ptr_q))) begin
                grant[i] = 1'b1;
                rr_found = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!rr_found && req_valid[i] && (i <= int'(ptr_q))) begin
                grant[i] = 1'b1;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                ptr_d = PW'(i);
            end
        end
    end

    // Reset to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= PW'(NREQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic fp_found;

    always_comb begin
        grant    = '0;
        fp_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!fp_found && req_valid[i]) begin
                grant[i] = 1'b1;
                fp_found = 1'b1;
            end
        end
    end
`endif

    assign req_ready = grant;
    assign accept    = |grant;

    // Grant is one-hot, so at most one leg of the mux is taken; with no grant the
    // address/data registers hold.
    always_comb begin
        acc_dest = waddr_q;
        acc_data = wdata_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                acc_dest = req_dest[5*i +: 5];
                acc_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        wen_d   = accept;
        waddr_d = acc_dest;
        wdata_d = acc_data;
    end

    assign issue_stall = issue_valid &
                         (pending_q[issue_src1] | pending_q[issue_src2] | pending_q[issue_dest]);

    // Clear on the edge the register file commits, so the stall drops exactly when
    // the new value becomes readable. The set is applied after the clear so a
    // same-register collision leaves the bit set; flush overrides both.
    always_comb begin
        pending_d = pending_q;
        if (wen_q) begin
            pending_d[waddr_q] = 1'b0;
        end
        if (flush) begin
            pending_d = '0;
        end else if (issue_valid && !issue_stall) begin
            pending_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            wen_q     <= wen_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign rf_writeEn   = wen_q;
    assign rf_dest_addr = waddr_q;
    assign rf_writeVal  = wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed arbitration, scoreboard and flush/reset scenarios.
// Expected write-backs are queued when a grant is observed and compared when rf_writeEn fires.
// Works for both arbitration builds; expected grant tables are selected by the same option.

module tb_rf_wb_arbiter;

    localparam int NREQ = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_dest;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_writeEn;
    logic [4:0]        rf_dest_addr;
    logic [31:0]       rf_writeVal;
    logic              issue_valid;
    logic [4:0]        issue_dest;
    logic [4:0]        issue_src1;
    logic [4:0]        issue_src2;
    logic              issue_stall;
    logic              flush;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  dest;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];

    // Expected grants: three contention cycles, and the grant in the reset cycle
    // (the last grant before it went to requester 0).
`ifdef RF_WB_ROUND_ROBIN_EN
    logic [2:0] exp_cont [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0] exp_rst_grant = 3'b010;
`else
    logic [2:0] exp_cont [3] = '{3'b001, 3'b001, 3'b001};
    logic [2:0] exp_rst_grant = 3'b001;
`endif

    rf_wb_arbiter #(.NREQ(NREQ)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rf_writeEn  (rf_writeEn),
        .rf_dest_addr(rf_dest_addr),
        .rf_writeVal (rf_writeVal),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_src1  (issue_src1),
        .issue_src2  (issue_src2),
        .issue_stall (issue_stall),
        .flush       (flush)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] d, input logic [31:0] v);
        req_dest[5*i +: 5]  = d;
        req_data[32*i +: 32] = v;
    endtask

    task automatic push_wb(input logic [4:0] d, input logic [31:0] v);
        wb_t e;
        e.dest = d;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic set_issue(input logic v, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        issue_valid = v;
        issue_dest  = d;
        issue_src1  = s1;
        issue_src2  = s2;
    endtask

    task automatic set_contention();
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 5'(10 + i), 32'hA000_0000 + 32'(i));
        end
        req_valid = 3'b111;
    endtask

    // Scoreboard monitor: every write-back must match the oldest queued expectation.
    always @(negedge clock) begin
        wb_t e;
        if (rf_writeEn === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("wb_unexpected", {32'd0, 27'd0, rf_dest_addr}, 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                check_val("wb_dest", {59'd0, rf_dest_addr}, {59'd0, e.dest});
                check_val("wb_data", {32'd0, rf_writeVal}, {32'd0, e.data});
            end
        end
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_dest  = '0;
        req_data  = '0;
        flush     = 1'b0;
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);

        // Reset state
        @(negedge clock);
        @(negedge clock);
        req_valid = 3'b111;
        set_issue(1'b1, 5'd1, 5'd2, 5'd3);
        #1;
        check_val("rst_wen",   {63'd0, rf_writeEn}, 64'd0);
        check_val("rst_addr",  {59'd0, rf_dest_addr}, 64'd0);
        check_val("rst_val",   {32'd0, rf_writeVal}, 64'd0);
        check_val("rst_ready", {61'd0, req_ready}, 64'd1);
        check_val("rst_stall", {63'd0, issue_stall}, 64'd0);
        req_valid = '0;
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("idle_ready", {61'd0, req_ready}, 64'd0);

        // Contention: all three valid for three cycles
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clock);
            set_contention();
            #1;
            check_val("cont_grant", {61'd0, req_ready}, {61'd0, exp_cont[c]});
            for (int i = 0; i < NREQ; i++) begin
                if (exp_cont[c][i]) push_wb(5'(10 + i), 32'hA000_0000 + 32'(i));
            end
            if (c > 0) check_val("cont_wen", {63'd0, rf_writeEn}, 64'd1);
        end
        @(negedge clock);
        req_valid = '0;
        #1;
        check_val("cont_wen_last", {63'd0, rf_writeEn}, 64'd1);
        @(negedge clock);
        #1;
        check_val("cont_wen_off", {63'd0, rf_writeEn}, 64'd0);

        // Single write
        @(negedge clock);
        set_req(0, 5'd5, 32'hDEADBEEF);
        req_valid = 3'b001;
        #1;
        check_val("single_ready", {61'd0, req_ready}, 64'd1);
        push_wb(5'd5, 32'hDEADBEEF);
        @(negedge clock);
        req_valid = '0;
        #1;
        check_val("single_wen",  {63'd0, rf_writeEn}, 64'd1);
        check_val("single_addr", {59'd0, rf_dest_addr}, 64'd5);
        check_val("single_val",  {32'd0, rf_writeVal}, 64'hDEADBEEF);
        @(negedge clock);
        #1;
        check_val("single_wen_off", {63'd0, rf_writeEn}, 64'd0);
        check_val("single_hold",    {59'd0, rf_dest_addr}, 64'd5);

        // RAW: dest 7 issued in M, src1 = 7 in M+1; MUL writes r7 granted in K = M+1
        @(negedge clock);
        set_issue(1'b1, 5'd7, 5'd1, 5'd2);
        #1;
        check_val("raw_issue", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b1, 5'd20, 5'd7, 5'd0);
        set_req(1, 5'd7, 32'h0000_0077);
        req_valid = 3'b010;
        #1;
        check_val("raw_stall",     {63'd0, issue_stall}, 64'd1);
        check_val("raw_mul_ready", {61'd0, req_ready}, 64'd2);
        push_wb(5'd7, 32'h0000_0077);
        @(negedge clock);
        req_valid = '0;
        #1;
        check_val("raw_stall_k1", {63'd0, issue_stall}, 64'd1);
        @(negedge clock);
        #1;
        check_val("raw_stall_k2", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);

        // WAW and set/clear collision
        @(negedge clock);
        set_issue(1'b1, 5'd9, 5'd1, 5'd2);
        #1;
        check_val("waw_first", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b1, 5'd9, 5'd0, 5'd0);
        set_req(0, 5'd3, 32'h0000_0033);
        req_valid = 3'b001;
        #1;
        check_val("waw_stall", {63'd0, issue_stall}, 64'd1);
        check_val("waw_ready", {61'd0, req_ready}, 64'd1);
        push_wb(5'd3, 32'h0000_0033);
        @(negedge clock);
        req_valid = '0;
        set_issue(1'b1, 5'd3, 5'd0, 5'd0);
        #1;
        check_val("coll_wen",   {63'd0, rf_writeEn}, 64'd1);
        check_val("coll_addr",  {59'd0, rf_dest_addr}, 64'd3);
        check_val("coll_issue", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b1, 5'd22, 5'd3, 5'd0);
        #1;
        check_val("coll_set_wins", {63'd0, issue_stall}, 64'd1);
        @(negedge clock);
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);

        // Flush with r4 and r12 pending and a grant to r4 in the flush cycle
        @(negedge clock);
        set_issue(1'b1, 5'd4, 5'd0, 5'd0);
        #1;
        check_val("fl_set4", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b1, 5'd12, 5'd0, 5'd0);
        #1;
        check_val("fl_set12", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        flush = 1'b1;
        set_issue(1'b1, 5'd25, 5'd0, 5'd0);
        set_req(0, 5'd4, 32'h0000_0044);
        req_valid = 3'b001;
        #1;
        check_val("fl_ready", {61'd0, req_ready}, 64'd1);
        check_val("fl_issue", {63'd0, issue_stall}, 64'd0);
        push_wb(5'd4, 32'h0000_0044);
        @(negedge clock);
        flush = 1'b0;
        req_valid = '0;
        set_issue(1'b1, 5'd26, 5'd12, 5'd25);
        #1;
        check_val("fl_cleared", {63'd0, issue_stall}, 64'd0);
        check_val("fl_wen",     {63'd0, rf_writeEn}, 64'd1);
        check_val("fl_addr",    {59'd0, rf_dest_addr}, 64'd4);
        @(negedge clock);
        set_issue(1'b1, 5'd27, 5'd4, 5'd9);
        #1;
        check_val("fl_clear_noop", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b0, 5'd28, 5'd26, 5'd0);
        #1;
        check_val("novalid_stall", {63'd0, issue_stall}, 64'd0);
        @(negedge clock);
        set_issue(1'b1, 5'd28, 5'd26, 5'd0);
        #1;
        check_val("post_fl_pending", {63'd0, issue_stall}, 64'd1);
        @(negedge clock);
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);

        // Reset mid-stream: grant and issue in the reset cycle are dropped
        @(negedge clock);
        reset = 1'b1;
        set_contention();
        set_issue(1'b1, 5'd30, 5'd0, 5'd0);
        #1;
        check_val("mid_rst_grant", {61'd0, req_ready}, {61'd0, exp_rst_grant});
        @(negedge clock);
        reset = 1'b0;
        set_issue(1'b1, 5'd31, 5'd30, 5'd26);
        #1;
        check_val("mid_rst_wen",   {63'd0, rf_writeEn}, 64'd0);
        check_val("mid_rst_stall", {63'd0, issue_stall}, 64'd0);
        check_val("mid_rst_first", {61'd0, req_ready}, 64'd1);
        push_wb(5'd10, 32'hA000_0000);
        @(negedge clock);
        req_valid = '0;
        set_issue(1'b0, 5'd0, 5'd0, 5'd0);
        #1;
        check_val("mid_rst_wb", {63'd0, rf_writeEn}, 64'd1);

        repeat (3) @(negedge clock);
        #1;
        check_val("wb_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and register scoreboard for the core's 32×32-bit register file. It shares the file's single write port (writeEn / dest_addr / writeVal) between NREQ execution-unit requesters and tracks pending destinations so the issue stage can stall on RAW/WAW hazards. It sits between the execute-stage units (ALU, MUL, load unit) and the register file, and feeds the decode/issue stall logic.

## Interface
- NREQ, 3, number of write-back requesters; index 0 = ALU, 1 = MUL, 2 = MEM
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a write-back pending
- req_dest  in  NREQ*5  destination register of requester i, bits [5i+:5]
- req_data  in  NREQ*32  write data of requester i, bits [32i+:32]
- req_ready  out  NREQ  one-hot grant; requester i's write is accepted this cycle
- rf_writeEn  out  1  register-file write enable (registered)
- rf_dest_addr  out  5  register-file write address (registered)
- rf_writeVal  out  32  register-file write data (registered)
- issue_valid  in  1  issue stage presents an instruction
- issue_dest  in  5  its destination register
- issue_src1  in  5  its first source register
- issue_src2  in  5  its second source register
- issue_stall  out  1  combinational; instruction must not issue
- flush  in  1  exception/iret flush; clears the scoreboard

## Operation
- Arbitration: req_ready[i] = grant[i], computed combinationally from req_valid and the arbitration state. At most one bit is set. req_ready is 0 when req_valid is all zero.
- Accepted write: a write is accepted when req_valid[i] & req_ready[i]. It is captured into the output register: rf_writeEn <= 1, rf_dest_addr <= req_dest[i], rf_writeVal <= req_data[i]. If no write is accepted, rf_writeEn <= 0 and address/data hold their previous values.
- Requester obligation: a requester holds valid, dest and data stable until it is granted. The arbiter does not check this.
- Scoreboard: pending[31:0] holds one bit per register.
  - issue_stall = issue_valid & (pending[issue_src1] | pending[issue_src2] | pending[issue_dest]).
  - Set: pending[issue_dest] is set at the clock edge when issue_valid & !issue_stall.
  - Clear: pending[rf_dest_addr] is cleared at the clock edge when rf_writeEn = 1. This is the same edge on which the register file commits the write.
  - Same-register set and clear in one cycle: set wins.
  - A clear of a register that is not pending is a no-op.
- Flush: pending is cleared to 0 at the next edge, and the set in that cycle is suppressed. Arbitration and the output register are unaffected, so in-flight write-backs still complete.
- Register 0 is tracked like any other register. This block does not hardwire it.
- Reset values: pending = 0, rf_writeEn = 0, rf_dest_addr = 0, rf_writeVal = 0, round-robin pointer = NREQ-1 (so requester 0 has first priority). req_ready and issue_stall follow combinationally from these values.

## Timing
- Requester granted in cycle N → rf_writeEn = 1 during N+1 → register file updated at end of N+1 → new value readable from cycle N+2.
- Pending bit cleared at end of N+1, so issue_stall on that register drops in N+2. This matches read-data availability and needs no bypass.
- Throughput: one write-back per cycle; back-to-back grants produce continuous rf_writeEn.
- Issue accepted in cycle M → pending set, visible to issue_stall from M+1.
- Reset asserted mid-operation: all state returns to reset values at that edge. Any captured write is dropped (rf_writeEn = 0 the next cycle).

## Configuration
- RF_WB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - The pointer holds the index of the last granted requester.
  - Search starts at pointer+1, wrapping modulo NREQ.
  - The pointer updates to i on every accepted grant and holds otherwise.
- RF_WB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins (ALU > MUL > MEM). The pointer is not implemented.

## Test plan
- Single write: req_valid = 3'b001, dest = 5, data = 0xDEADBEEF in cycle N → req_ready = 3'b001 in N; rf_writeEn = 1, rf_dest_addr = 5, rf_writeVal = 0xDEADBEEF in N+1; rf_writeEn = 0 in N+2.
- Contention, all three valid for 3 cycles:
  - with RF_WB_ROUND_ROBIN_EN: grants 0, 1, 2;
  - without: grant 0 every cycle while req_valid[0] stays high.
- RAW stall: issue dest = 7 accepted in M, then issue src1 = 7 in M+1 → issue_stall = 1. MUL writes r7 (granted in K) → issue_stall = 0 from K+2.
- WAW and set/clear collision: dest = 9 pending, issue dest = 9 → stall. rf_writeEn to r3 coinciding with issue dest = 3 (r3 not pending) → pending[3] = 1 afterwards.
- Flush: pending = {r4, r12} with a grant to r4 in the flush cycle → pending = 0 next cycle, issue of src = 12 not stalled, and the r4 write still appears on rf_writeEn.
- Reset mid-stream: grant in N, reset asserted in N → rf_writeEn = 0 in N+1, pending = 0, and the next contention grants requester 0 first.
